// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-access stage.
// Pure definitions, no timing.
// No flow control of its own.
package mem_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   // Access size, taken from funct3[1:0]
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // Byte mask per size, packed lowest size in the lowest byte
   localparam logic [31:0] SIZE_BE_MASK = {8'hFF, 8'h0F, 8'h03, 8'h01};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_e;

   // Unshifted byte-enable pattern for an access size
   function automatic logic [7:0] size_be(input logic [1:0] size);
      return SIZE_BE_MASK[{size, 3'b000} +: 8];
   endfunction

   // Natural alignment check; bytes are never misaligned
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         SZ_H:    return off[0];
         SZ_W:    return |off[1:0];
         SZ_D:    return |off;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: shift the doubleword down to the accessed lane and extend.
// Purely combinational, zero latency.
// No flow control; output valid whenever inputs are.
module load_align
   import mem_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   output logic [63:0] data
);

   logic [63:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   // Select width and sign/zero extension from the load funct3
   always_comb begin
      data = shifted;
      case (funct3)
         F3_LB:   data = {{56{shifted[7]}},  shifted[7:0]};
         F3_LBU:  data = {56'd0,             shifted[7:0]};
         F3_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
         F3_LHU:  data = {48'd0,             shifted[15:0]};
         F3_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
         F3_LWU:  data = {32'd0,             shifted[31:0]};
         F3_LD:   data = shifted;
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues one load/store per instruction over req/gnt/rvalid, feeds MEM/WB.
// Latency: non-mem 0 cycles; store >= 2 cycles; load >= 3 cycles (request registered).
// Backpressure: stall_o held while a transaction is outstanding; gnt/rvalid may be delayed.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            reg_write_i,
   input  logic            mem_read_i,
   input  logic            mem_write_i,
   input  logic [2:0]      funct3_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [7:0]      dmem_be_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic [XLEN-1:0] alu_result_o,
   output logic [XLEN-1:0] mem_data_o,
   output logic [4:0]      rd_addr_o,
   output logic            reg_write_o,
   output logic            mem_to_reg_o,
   output logic            stall_o,
   output logic            misalign_o
);

   mem_state_e state_q, state_d;

   // Captured request; held stable until the memory grants it
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [7:0]      be_q;
   logic            we_q;
   logic [2:0]      funct3_q;
   logic [2:0]      off_q;

   logic            mem_op;
   logic            misaligned;
   logic            start;
   logic [2:0]      off_in;
   logic [1:0]      size_in;
   logic [XLEN-1:0] load_data;

   assign off_in     = alu_result_i[2:0];
   assign size_in    = funct3_i[1:0];
   assign mem_op     = mem_read_i | mem_write_i;
   assign misaligned = is_misaligned(size_in, off_in);
   assign start      = (state_q == IDLE) && valid_i && mem_op && !misaligned;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: one request per op; loads additionally wait for rvalid after gnt
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = REQ;
         end
         REQ: begin
            // rvalid arriving with gnt belongs to no one yet, so it is dropped here
            if (dmem_gnt_i) state_d = we_q ? IDLE : WAIT;
         end
         WAIT: begin
            if (dmem_rvalid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the lane-shifted request when an aligned op is first seen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         off_q    <= '0;
      end else if (start) begin
         addr_q   <= {alu_result_i[XLEN-1:3], 3'b000};
         wdata_q  <= store_data_i << {off_in, 3'b000};
         be_q     <= size_be(size_in) << off_in;
         we_q     <= mem_write_i;
         funct3_q <= funct3_i;
         off_q    <= off_in;
      end
   end

   load_align u_load_align (
      .rdata  (dmem_rdata_i),
      .offset (off_q),
      .funct3 (funct3_q),
      .data   (load_data)
   );

   // Memory port driven from registered state only; quiet outside REQ
   always_comb begin
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_wdata_o = '0;
      dmem_be_o    = '0;
      if (state_q == REQ) begin
         dmem_req_o   = 1'b1;
         dmem_we_o    = we_q;
         dmem_addr_o  = addr_q;
         dmem_wdata_o = wdata_q;
         dmem_be_o    = be_q;
      end
   end

   // MEM/WB outputs: bubble (reg_write 0, stall 1) on every non-completion cycle of a mem op
   always_comb begin
      alu_result_o = '0;
      mem_data_o   = '0;
      rd_addr_o    = '0;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      stall_o      = 1'b0;
      misalign_o   = 1'b0;
      if (!rst) begin
         if (valid_i || state_q != IDLE) begin
            alu_result_o = alu_result_i;
            rd_addr_o    = rd_addr_i;
         end
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  if (!mem_op) begin
                     reg_write_o = reg_write_i;
                  end else if (misaligned) begin
                     misalign_o = 1'b1;
                  end else begin
                     stall_o = 1'b1;
                  end
               end
            end
            REQ: begin
               if (dmem_gnt_i && we_q) begin
                  reg_write_o = reg_write_i;
               end else begin
                  stall_o = 1'b1;
               end
            end
            WAIT: begin
               if (dmem_rvalid_i) begin
                  reg_write_o  = reg_write_i;
                  mem_to_reg_o = 1'b1;
                  mem_data_o   = load_data;
               end else begin
                  stall_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops
// checked against a byte-lane arithmetic model of loads, stores and stall counts.
module tb_mem_access_stage;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic [63:0] alu_result_i;
   logic [63:0] store_data_i;
   logic [4:0]  rd_addr_i;
   logic        reg_write_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [2:0]  funct3_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [63:0] dmem_addr_o;
   logic [63:0] dmem_wdata_o;
   logic [7:0]  dmem_be_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [63:0] dmem_rdata_i;
   logic [63:0] alu_result_o;
   logic [63:0] mem_data_o;
   logic [4:0]  rd_addr_o;
   logic        reg_write_o;
   logic        mem_to_reg_o;
   logic        stall_o;
   logic        misalign_o;

   int errors = 0;
   int checks = 0;

   mem_access_stage #(.XLEN(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_i       (valid_i),
      .alu_result_i  (alu_result_i),
      .store_data_i  (store_data_i),
      .rd_addr_i     (rd_addr_i),
      .reg_write_i   (reg_write_i),
      .mem_read_i    (mem_read_i),
      .mem_write_i   (mem_write_i),
      .funct3_i      (funct3_i),
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .dmem_addr_o   (dmem_addr_o),
      .dmem_wdata_o  (dmem_wdata_o),
      .dmem_be_o     (dmem_be_o),
      .dmem_gnt_i    (dmem_gnt_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i),
      .alu_result_o  (alu_result_o),
      .mem_data_o    (mem_data_o),
      .rd_addr_o     (rd_addr_o),
      .reg_write_o   (reg_write_o),
      .mem_to_reg_o  (mem_to_reg_o),
      .stall_o       (stall_o),
      .misalign_o    (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: bytes touched = 2^size, lanes start at addr[2:0]
   function automatic logic [7:0] exp_be(input logic [2:0] f3, input logic [2:0] off);
      int n;
      logic [15:0] t;
      n = 1 << f3[1:0];
      t = 16'((1 << n) - 1) << off;
      return t[7:0];
   endfunction

   function automatic logic [63:0] exp_load(input logic [63:0] rdat, input logic [2:0] off,
                                             input logic [2:0] f3);
      int nbits;
      logic [63:0] v;
      logic [63:0] m;
      nbits = 8 * (1 << f3[1:0]);
      v = rdat >> (8 * off);
      m = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
      v = v & m;
      if (!f3[2] && v[nbits-1]) v = v | ~m;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid_i = 1'b1; alu_result_i = 64'hABC; store_data_i = '0; rd_addr_i = 5'd3;
      reg_write_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = '0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      #2;
      checks++;
      if (alu_result_o !== 64'd0 || reg_write_o !== 1'b0 || rd_addr_o !== 5'd0 ||
          stall_o !== 1'b0 || dmem_req_o !== 1'b0 || misalign_o !== 1'b0 || mem_data_o !== 64'd0) begin
         errors++;
         $display("FAIL reset_outputs: alu=%h rw=%b rd=%0d stall=%b req=%b mis=%b, need all zero",
                  alu_result_o, reg_write_o, rd_addr_o, stall_o, dmem_req_o, misalign_o);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      valid_i = 1'b0;
      #1;
      checks++;
      if (alu_result_o !== 64'd0 || reg_write_o !== 1'b0 || stall_o !== 1'b0 || dmem_req_o !== 1'b0 ||
          dmem_addr_o !== 64'd0 || dmem_be_o !== 8'd0) begin
         errors++;
         $display("FAIL idle_no_valid: alu=%h rw=%b stall=%b req=%b addr=%h be=%h, need all zero",
                  alu_result_o, reg_write_o, stall_o, dmem_req_o, dmem_addr_o, dmem_be_o);
      end
   endtask

   // Drop valid and check every output returns to zero
   task automatic idle();
      step();
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (alu_result_o !== 64'd0 || reg_write_o !== 1'b0 || stall_o !== 1'b0 || dmem_req_o !== 1'b0 ||
          mem_to_reg_o !== 1'b0 || dmem_wdata_o !== 64'd0 || dmem_be_o !== 8'd0) begin
         errors++;
         $display("FAIL idle_outputs: alu=%h rw=%b stall=%b req=%b m2r=%b be=%h, need all zero",
                  alu_result_o, reg_write_o, stall_o, dmem_req_o, mem_to_reg_o, dmem_be_o);
      end
   endtask

   task automatic test_alu(input logic [63:0] alu, input logic [4:0] rd, input logic rw);
      step();
      valid_i = 1'b1; alu_result_i = alu; rd_addr_i = rd; reg_write_i = rw;
      mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'($urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if (alu_result_o !== alu || rd_addr_o !== rd || reg_write_o !== rw || stall_o !== 1'b0 ||
          dmem_req_o !== 1'b0 || mem_to_reg_o !== 1'b0 || misalign_o !== 1'b0 || mem_data_o !== 64'd0) begin
         errors++;
         $display("FAIL alu_pass: alu=%h rd=%0d rw=%b stall=%b req=%b m2r=%b, need alu=%h rd=%0d rw=%b stall=0 req=0 m2r=0",
                  alu_result_o, rd_addr_o, reg_write_o, stall_o, dmem_req_o, mem_to_reg_o, alu, rd, rw);
      end
   endtask

   task automatic test_misalign(input bit ld, input logic [2:0] f3, input logic [63:0] addr);
      step();
      valid_i = 1'b1; alu_result_i = addr; store_data_i = {$urandom, $urandom}; rd_addr_i = 5'd9;
      reg_write_i = ld; mem_read_i = ld; mem_write_i = !ld; funct3_i = f3;
      @(negedge clk);
      checks++;
      if (misalign_o !== 1'b1 || dmem_req_o !== 1'b0 || stall_o !== 1'b0 || reg_write_o !== 1'b0) begin
         errors++;
         $display("FAIL misalign_flag: mis=%b req=%b stall=%b rw=%b, need mis=1 req=0 stall=0 rw=0",
                  misalign_o, dmem_req_o, stall_o, reg_write_o);
      end
      step();
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      @(negedge clk);
      checks++;
      if (misalign_o !== 1'b0 || dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL misalign_after: mis=%b req=%b stall=%b, need 0 0 0", misalign_o, dmem_req_o, stall_o);
      end
   endtask

   // One aligned load/store with gdly cycles of withheld gnt and rdly of withheld rvalid
   task automatic test_mem_op(input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] sdata, input logic [63:0] rdat,
                              input int gdly, input int rdly, input bit gr_same, input logic [4:0] rd);
      logic [63:0] e_addr;
      logic [63:0] e_wdata;
      logic [63:0] e_ld;
      logic [7:0]  e_be;
      int stalls;
      int e_stalls;
      e_addr   = {addr[63:3], 3'b000};
      e_wdata  = sdata << (8 * addr[2:0]);
      e_be     = exp_be(f3, addr[2:0]);
      e_ld     = exp_load(rdat, addr[2:0], f3);
      e_stalls = 1 + gdly + (ld ? 1 + rdly : 0);
      stalls   = 0;

      step();
      valid_i = 1'b1; alu_result_i = addr; store_data_i = sdata; rd_addr_i = rd;
      reg_write_i = ld; mem_read_i = ld; mem_write_i = !ld; funct3_i = f3;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (dmem_req_o !== 1'b0 || stall_o !== 1'b1 || reg_write_o !== 1'b0) begin
         errors++;
         $display("FAIL first_cycle: req=%b stall=%b rw=%b, need req=0 stall=1 rw=0",
                  dmem_req_o, stall_o, reg_write_o);
      end
      if (stall_o === 1'b1) stalls++;

      for (int c = 0; c <= gdly; c++) begin
         step();
         dmem_gnt_i    = (c == gdly);
         dmem_rvalid_i = (c == gdly) && gr_same;
         dmem_rdata_i  = 64'hDEAD_DEAD_DEAD_DEAD;
         @(negedge clk);
         checks++;
         if (dmem_req_o !== 1'b1 || dmem_addr_o !== e_addr || dmem_be_o !== e_be ||
             dmem_we_o !== !ld || dmem_wdata_o !== e_wdata) begin
            errors++;
            $display("FAIL req_fields: req=%b addr=%h be=%h we=%b wdata=%h, need req=1 addr=%h be=%h we=%b wdata=%h",
                     dmem_req_o, dmem_addr_o, dmem_be_o, dmem_we_o, dmem_wdata_o, e_addr, e_be, !ld, e_wdata);
         end
         checks++;
         if (!ld && c == gdly) begin
            if (stall_o !== 1'b0 || reg_write_o !== 1'b0 || mem_to_reg_o !== 1'b0 ||
                rd_addr_o !== rd || alu_result_o !== addr) begin
               errors++;
               $display("FAIL store_done: stall=%b rw=%b m2r=%b rd=%0d alu=%h, need stall=0 rw=0 m2r=0 rd=%0d alu=%h",
                        stall_o, reg_write_o, mem_to_reg_o, rd_addr_o, alu_result_o, rd, addr);
            end
         end else if (stall_o !== 1'b1 || reg_write_o !== 1'b0) begin
            errors++;
            $display("FAIL req_stall: stall=%b rw=%b, need stall=1 rw=0", stall_o, reg_write_o);
         end
         if (stall_o === 1'b1) stalls++;
      end

      if (ld) begin
         for (int c = 0; c <= rdly; c++) begin
            step();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = (c == rdly);
            dmem_rdata_i  = (c == rdly) ? rdat : ~rdat;
            @(negedge clk);
            checks++;
            if (c == rdly) begin
               if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || reg_write_o !== 1'b1 ||
                   mem_to_reg_o !== 1'b1 || mem_data_o !== e_ld || rd_addr_o !== rd) begin
                  errors++;
                  $display("FAIL load_done: req=%b stall=%b rw=%b m2r=%b data=%h rd=%0d, need req=0 stall=0 rw=1 m2r=1 data=%h rd=%0d",
                           dmem_req_o, stall_o, reg_write_o, mem_to_reg_o, mem_data_o, rd_addr_o, e_ld, rd);
               end
            end else if (dmem_req_o !== 1'b0 || stall_o !== 1'b1 || reg_write_o !== 1'b0) begin
               errors++;
               $display("FAIL wait_stall: req=%b stall=%b rw=%b, need req=0 stall=1 rw=0",
                        dmem_req_o, stall_o, reg_write_o);
            end
            if (stall_o === 1'b1) stalls++;
         end
      end

      checks++;
      if (stalls != e_stalls) begin
         errors++;
         $display("FAIL stall_count: got %0d cycles, need %0d", stalls, e_stalls);
      end
   endtask

   // Reset asserted while an LD is in REQ (in_wait=0) or WAIT (in_wait=1)
   task automatic test_reset_mid(input bit in_wait);
      step();
      valid_i = 1'b1; alu_result_i = 64'h5000; rd_addr_i = 5'd7; reg_write_i = 1'b1;
      mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b011;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      step();
      if (in_wait) begin
         dmem_gnt_i = 1'b1;
         step();
         dmem_gnt_i = 1'b0;
      end
      #1;
      checks++;
      if (dmem_req_o !== !in_wait || stall_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_pre: req=%b stall=%b, need req=%b stall=1", dmem_req_o, stall_o, !in_wait);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || reg_write_o !== 1'b0 || alu_result_o !== 64'd0) begin
         errors++;
         $display("FAIL reset_mid_drop: req=%b stall=%b rw=%b alu=%h, need all zero",
                  dmem_req_o, stall_o, reg_write_o, alu_result_o);
      end
      @(negedge clk);
      rst = 1'b0;
      valid_i = 1'b0; mem_read_i = 1'b0;
      step();
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 64'hDEAD;
      @(negedge clk);
      checks++;
      if (reg_write_o !== 1'b0 || mem_to_reg_o !== 1'b0 || mem_data_o !== 64'd0 ||
          dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL stale_rvalid: rw=%b m2r=%b data=%h req=%b stall=%b, need all zero",
                  reg_write_o, mem_to_reg_o, mem_data_o, dmem_req_o, stall_o);
      end
      step();
      dmem_rvalid_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      test_mem_op(1'b1, 3'b011, 64'h4000, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1, 1'b1, 5'd12);
      test_mem_op(1'b0, 3'b011, 64'h4008, 64'hCAFE_F00D_1234_5678, 64'd0, 1, 0, 1'b0, 5'd0);
      idle();
   endtask

   task automatic test_random();
      int kind;
      bit ld;
      logic [2:0] f3;
      logic [63:0] a;
      logic [63:0] d;
      logic [63:0] r;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         a = {$urandom, $urandom};
         d = {$urandom, $urandom};
         r = {$urandom, $urandom};
         if (kind < 2) begin
            test_alu(a, 5'($urandom), 1'($urandom));
         end else begin
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            if (kind == 2 && f3[1:0] != 2'd0) begin
               a[0] = 1'b1;
               test_misalign(ld, f3, a);
            end else begin
               a = a & ~((64'd1 << f3[1:0]) - 64'd1);
               test_mem_op(ld, f3, a, d, r, $urandom_range(0, 2), $urandom_range(0, 2),
                           1'($urandom_range(0, 1)), 5'($urandom));
            end
         end
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_alu(64'h1234, 5'd5, 1'b1);
      idle();
      test_mem_op(1'b1, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 5'd6);
      idle();
      test_mem_op(1'b1, 3'b100, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 5'd6);
      idle();
      test_mem_op(1'b0, 3'b001, 64'h2006, 64'hBEEF, 64'd0, 3, 0, 1'b0, 5'd0);
      idle();
      test_misalign(1'b1, 3'b010, 64'h3002);
      test_reset_mid(1'b1);
      test_reset_mid(1'b0);
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
